// File: rtl/ob.sv
// ----------------------------------------------------------------------------
// ob -- output buffer terminating one switch output port.
//
// Accepts packets from a crossbar output, drops those routed to a different
// port (counted as errors), queues correctly routed packets in a small FIFO
// and presents the FIFO head to the local sink with a valid/ready handshake.
// A full FIFO drops new arrivals unless the head leaves in the same cycle.
//
// Parameters
//   PKTW    : packet bus MSB index (bus is PKTW+1 bits)
//   PORT_ID : 2-bit index of the output this block terminates
//   DEPTH   : FIFO entries, power of 2, >= 2
//
// Ports
//   clk     : clock, rising edge
//   rst     : synchronous active-low reset
//   i       : incoming packet {valid, dest[1:0], payload}
//   o       : FIFO head packet (read straight from storage)
//   ov      : o holds a valid packet
//   ordy    : sink ready; transfer when ov && ordy at a rising edge
//   xoff    : registered backpressure hint (occupancy >= DEPTH-1)
//   occ     : FIFO occupancy
//   rxcnt   : accepted packets, wraps
//   dropcnt : packets dropped on a full FIFO, saturates
//   errcnt  : misrouted packets, saturates
// ----------------------------------------------------------------------------
module ob #(
    parameter int PKTW    = 15,
    parameter int PORT_ID = 0,
    parameter int DEPTH   = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [PKTW:0]            i,
    output logic [PKTW:0]            o,
    output logic                     ov,
    input  logic                     ordy,
    output logic                     xoff,
    output logic [$clog2(DEPTH):0]   occ,
    output logic [15:0]              rxcnt,
    output logic [7:0]               dropcnt,
    output logic [7:0]               errcnt
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);
    localparam logic [AW:0] HI_C    = (AW+1)'(DEPTH - 1);
    localparam logic [1:0]  PID_C   = 2'(PORT_ID);

    logic [PKTW:0]   mem_r [DEPTH];
    logic [AW-1:0]   wptr_r;
    logic [AW-1:0]   rptr_r;
    logic [AW:0]     occ_r;
    logic            xoff_r;
    logic [15:0]     rxcnt_r;
    logic [7:0]      dropcnt_r;
    logic [7:0]      errcnt_r;

    logic            routed_s;
    logic            mis_s;
    logic            xfer_s;
    logic            enq_s;
    logic            drop_s;

    // Classify the arrival and decide enqueue / drop / transfer this cycle.
    always_comb begin
        routed_s = i[PKTW] && (i[PKTW-1:PKTW-2] == PID_C);
        mis_s    = i[PKTW] && (i[PKTW-1:PKTW-2] != PID_C);
        xfer_s   = ov && ordy;
        // A full FIFO still accepts when the head leaves in the same cycle.
        enq_s    = routed_s && ((occ_r != DEPTH_C) || xfer_s);
        drop_s   = routed_s && !enq_s;
    end

    // Head and valid come straight from storage/occupancy: no bypass path.
    assign o       = mem_r[rptr_r];
    assign ov      = (occ_r != {(AW+1){1'b0}});
    assign occ     = occ_r;
    assign xoff    = xoff_r;
    assign rxcnt   = rxcnt_r;
    assign dropcnt = dropcnt_r;
    assign errcnt  = errcnt_r;

    // FIFO storage; contents are deliberately left unreset, writes blocked in reset.
    always_ff @(posedge clk) begin
        if (rst && enq_s) begin
            mem_r[wptr_r] <= i;
        end
    end

    // Pointers, occupancy, backpressure and statistics counters.
    always_ff @(posedge clk) begin
        if (!rst) begin
            wptr_r    <= {AW{1'b0}};
            rptr_r    <= {AW{1'b0}};
            occ_r     <= {(AW+1){1'b0}};
            xoff_r    <= 1'b0;
            rxcnt_r   <= 16'd0;
            dropcnt_r <= 8'd0;
            errcnt_r  <= 8'd0;
        end else begin
            // Pointers wrap naturally because DEPTH is a power of 2.
            if (enq_s) begin
                wptr_r <= wptr_r + 1'b1;
            end
            if (xfer_s) begin
                rptr_r <= rptr_r + 1'b1;
            end
            case ({enq_s, xfer_s})
                2'b10:   occ_r <= occ_r + 1'b1;
                2'b01:   occ_r <= occ_r - 1'b1;
                default: occ_r <= occ_r;
            endcase
            // Lags occupancy by one cycle; the two thresholds are adjacent.
            xoff_r <= (occ_r >= HI_C);
            if (enq_s) begin
                rxcnt_r <= rxcnt_r + 16'd1;
            end
            if (drop_s && (dropcnt_r != 8'hFF)) begin
                dropcnt_r <= dropcnt_r + 8'd1;
            end
            if (mis_s && (errcnt_r != 8'hFF)) begin
                errcnt_r <= errcnt_r + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_ob.sv
module tb_ob;

    logic        clk;
    logic        rst;
    logic [15:0] i1, o1, i0, o0;
    logic        ov1, ordy1, xoff1, ov0, ordy0, xoff0;
    logic [2:0]  occ1, occ0;
    logic [15:0] rxcnt1, rxcnt0;
    logic [7:0]  dropcnt1, errcnt1, dropcnt0, errcnt0;

    int n_vec;
    int n_err;

    ob #(.PKTW(15), .PORT_ID(1), .DEPTH(4)) u_ob1 (
        .clk(clk), .rst(rst), .i(i1), .o(o1), .ov(ov1), .ordy(ordy1),
        .xoff(xoff1), .occ(occ1), .rxcnt(rxcnt1), .dropcnt(dropcnt1),
        .errcnt(errcnt1)
    );

    ob #(.PKTW(15), .PORT_ID(0), .DEPTH(4)) u_ob0 (
        .clk(clk), .rst(rst), .i(i0), .o(o0), .ov(ov0), .ordy(ordy0),
        .xoff(xoff0), .occ(occ0), .rxcnt(rxcnt0), .dropcnt(dropcnt0),
        .errcnt(errcnt0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One rising edge, then settle before sampling.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [15:0] exp_q [4];

    initial begin
        n_vec = 0;
        n_err = 0;
        rst   = 1'b0;
        i1 = 16'h0000; i0 = 16'h0000;
        ordy1 = 1'b0;  ordy0 = 1'b0;
        tick();
        tick();
        rst = 1'b1;

        // Reset state
        check("rst_occ",  32'(occ1), 32'd0);
        check("rst_ov",   32'(ov1), 32'd0);
        check("rst_xoff", 32'(xoff1), 32'd0);
        check("rst_rx",   32'(rxcnt1), 32'd0);
        check("rst_drop", 32'(dropcnt1), 32'd0);
        check("rst_err",  32'(errcnt1), 32'd0);

        // Single routed packet (dest 1), sink ready
        i1 = 16'hA0A5; ordy1 = 1'b1;
        tick();
        i1 = 16'h0000;
        check("single_ov",  32'(ov1), 32'd1);
        check("single_o",   32'(o1), 32'hA0A5);
        check("single_rx",  32'(rxcnt1), 32'd1);
        check("single_occ1", 32'(occ1), 32'd1);
        tick();
        check("single_ov_gone", 32'(ov1), 32'd0);
        check("single_occ0", 32'(occ1), 32'd0);

        // 16'hC0A5 carries destination 2: misrouted at port 1
        i1 = 16'hC0A5;
        tick();
        i1 = 16'h0000;
        check("mis1_err", 32'(errcnt1), 32'd1);
        check("mis1_ov",  32'(ov1), 32'd0);
        check("mis1_rx",  32'(rxcnt1), 32'd1);

        // Overflow: six routed packets with the sink stalled
        ordy1 = 1'b0;
        for (int k = 0; k < 6; k++) begin
            i1 = 16'hA010 + 16'(k);
            tick();
            check("ovf_occ", 32'(occ1), (k < 4) ? 32'(k + 1) : 32'd4);
        end
        i1 = 16'h0000;
        check("ovf_drop", 32'(dropcnt1), 32'd2);
        check("ovf_rx",   32'(rxcnt1), 32'd5);
        check("ovf_xoff", 32'(xoff1), 32'd1);
        tick();
        check("stall_o", 32'(o1), 32'hA010);
        check("stall_ov", 32'(ov1), 32'd1);

        // Full with simultaneous transfer: arrival accepted
        i1 = 16'hA020; ordy1 = 1'b1;
        tick();
        i1 = 16'h0000;
        check("fullx_occ",  32'(occ1), 32'd4);
        check("fullx_drop", 32'(dropcnt1), 32'd2);
        check("fullx_rx",   32'(rxcnt1), 32'd6);

        exp_q[0] = 16'hA011; exp_q[1] = 16'hA012;
        exp_q[2] = 16'hA013; exp_q[3] = 16'hA020;
        for (int k = 0; k < 4; k++) begin
            check("drain_o", 32'(o1), 32'(exp_q[k]));
            tick();
        end
        check("drain_ov", 32'(ov1), 32'd0);
        tick();
        check("drain_xoff", 32'(xoff1), 32'd0);

        // Reset in mid-stream with three packets queued
        ordy1 = 1'b0;
        for (int k = 0; k < 3; k++) begin
            i1 = 16'hA031 + 16'(k);
            tick();
        end
        i1 = 16'h0000;
        tick();
        check("pre_rst_occ",  32'(occ1), 32'd3);
        check("pre_rst_xoff", 32'(xoff1), 32'd1);
        rst = 1'b0; i1 = 16'hA099; ordy1 = 1'b1;
        tick();
        rst = 1'b1; i1 = 16'h0000; ordy1 = 1'b0;
        check("mrst_occ",  32'(occ1), 32'd0);
        check("mrst_ov",   32'(ov1), 32'd0);
        check("mrst_xoff", 32'(xoff1), 32'd0);
        check("mrst_rx",   32'(rxcnt1), 32'd0);
        check("mrst_drop", 32'(dropcnt1), 32'd0);
        check("mrst_err",  32'(errcnt1), 32'd0);
        i1 = 16'hA040;
        tick();
        i1 = 16'h0000;
        check("post_rst_ov", 32'(ov1), 32'd1);
        check("post_rst_o",  32'(o1), 32'hA040);
        check("post_rst_rx", 32'(rxcnt1), 32'd1);
        ordy1 = 1'b1;
        tick();

        // Pointer wrap: ten enqueue/dequeue pairs with ordy toggling
        for (int k = 0; k < 10; k++) begin
            i1 = 16'hA050 + 16'(k); ordy1 = 1'b0;
            tick();
            i1 = 16'h0000;
            check("wrap_o", 32'(o1), 32'(16'hA050 + 16'(k)));
            ordy1 = 1'b1;
            tick();
        end
        check("wrap_occ",  32'(occ1), 32'd0);
        check("wrap_drop", 32'(dropcnt1), 32'd0);
        check("wrap_rx",   32'(rxcnt1), 32'd11);

        // Port 0 instance: misroute to dest 2, then saturation
        ordy0 = 1'b1;
        i0 = 16'hC001;
        tick();
        i0 = 16'h0000;
        check("mis0_err", 32'(errcnt0), 32'd1);
        check("mis0_occ", 32'(occ0), 32'd0);
        check("mis0_ov",  32'(ov0), 32'd0);
        for (int k = 0; k < 299; k++) begin
            i0 = 16'hC000 | 16'(k & 255);
            tick();
        end
        i0 = 16'h0000;
        check("mis0_sat", 32'(errcnt0), 32'd255);
        check("mis0_rx",  32'(rxcnt0), 32'd0);
        i0 = 16'h8077; ordy0 = 1'b0;
        tick();
        i0 = 16'h0000;
        check("p0_ov", 32'(ov0), 32'd1);
        check("p0_o",  32'(o0), 32'h8077);
        check("p0_rx", 32'(rxcnt0), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
